// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants and types for seven-segment display stages.
//   - SEG_0..SEG_9: active-low {g,f,e,d,c,b,a} patterns for decimal digits
//   - SEG_BLANK   : all segments off
//   - BLANK_CODE  : digit code that renders as a blank digit
//   - digit_idx_t : scan index for a 4-digit multiplexed display
package seg7_pkg;

  typedef logic [1:0] digit_idx_t;

  localparam logic [3:0] BLANK_CODE = 4'hF;
  localparam logic [6:0] SEG_BLANK  = 7'h7F;

  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: combinational 4-bit digit code to active-low segment pattern.
// Ports:
//   i_code  in  4  digit code; 0..9 are digits, every other code renders blank
//   o_seg   out 7  segment pattern {g,f,e,d,c,b,a}, active-low
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] i_code,
  output logic [6:0] o_seg
);

  // Code to pattern lookup; undefined codes blank the digit
  always_comb begin
    o_seg = SEG_BLANK;
    case (i_code)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/countdown_display.sv
// countdown_display: 4-digit multiplexed seven-segment display for the
// down-counter. Digits 1:0 show the live count value, digits 3:2 show a BCD
// count (00..99) of edges seen on the counter's divide flag.
// Ports:
//   clk       in  1  system clock (counter's clock domain)
//   rst       in  1  asynchronous active-high reset
//   in_val    in  4  count value from upstream (all 16 codes accepted)
//   in_flag   in  1  divide flag; every edge is one event
//   seg       out 7  segment drive {g,f,e,d,c,b,a}, active-low, registered
//   an        out 4  digit enables, active-low one-hot, an[0] rightmost
//   evt_tick  out 1  one-cycle pulse per detected in_flag edge
module countdown_display
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] in_val,
  input  logic       in_flag,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       evt_tick
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  logic [3:0]       r_val;
  logic             r_flag;
  logic             r_flag_d;
  logic [3:0]       r_evt_ones;
  logic [3:0]       r_evt_tens;
  digit_idx_t       r_idx;
  logic [DIV_W-1:0] r_div_cnt;

  logic             w_evt;
  logic             w_div_tc;
  logic [3:0]       w_val_tens;
  logic [3:0]       w_val_ones;
  logic [3:0]       w_code;
  logic [6:0]       w_seg;
  logic [3:0]       w_an;

  assign w_evt    = r_flag ^ r_flag_d;
  assign w_div_tc = (r_div_cnt == DIV_LAST);
  assign w_an     = ~(4'b0001 << r_idx);

  // Input registers and edge-detect delay stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_val    <= 4'd0;
      r_flag   <= 1'b0;
      r_flag_d <= 1'b0;
    end else begin
      r_val    <= in_val;
      r_flag   <= in_flag;
      r_flag_d <= r_flag;
    end
  end

  // Two-digit BCD event counter, wraps 99 -> 00
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_evt_ones <= 4'd0;
      r_evt_tens <= 4'd0;
    end else if (w_evt) begin
      if (r_evt_ones == 4'd9) begin
        r_evt_ones <= 4'd0;
        if (r_evt_tens == 4'd9) begin
          r_evt_tens <= 4'd0;
        end else begin
          r_evt_tens <= r_evt_tens + 4'd1;
        end
      end else begin
        r_evt_ones <= r_evt_ones + 4'd1;
      end
    end else begin
      r_evt_ones <= r_evt_ones;
      r_evt_tens <= r_evt_tens;
    end
  end

  // Scan divider: each digit stays lit for SCAN_DIV cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div_cnt <= '0;
      r_idx     <= 2'd0;
    end else if (w_div_tc) begin
      r_div_cnt <= '0;
      r_idx     <= r_idx + 2'd1;
    end else begin
      r_div_cnt <= r_div_cnt + DIV_W'(1);
      r_idx     <= r_idx;
    end
  end

  // Split the count value into tens/ones; a blank tens digit suppresses the
  // leading zero for values below 10
  always_comb begin
    w_val_tens = BLANK_CODE;
    w_val_ones = r_val;
    if (r_val >= 4'd10) begin
      w_val_tens = 4'd1;
      w_val_ones = r_val - 4'd10;
    end else begin
      w_val_tens = BLANK_CODE;
      w_val_ones = r_val;
    end
  end

  // Digit mux: select the code for the digit currently being scanned.
  // The event tens digit is never blanked so "00" stays visible.
  always_comb begin
    w_code = BLANK_CODE;
    case (r_idx)
      2'd0:    w_code = w_val_ones;
      2'd1:    w_code = w_val_tens;
      2'd2:    w_code = r_evt_ones;
      2'd3:    w_code = r_evt_tens;
      default: w_code = BLANK_CODE;
    endcase
  end

  seg7_decode u_decode (
    .i_code (w_code),
    .o_seg  (w_seg)
  );

  // Output registers: anode and pattern come from the same index, so a digit
  // change never shows the previous digit's pattern
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg      <= SEG_BLANK;
      an       <= 4'hF;
      evt_tick <= 1'b0;
    end else begin
      seg      <= w_seg;
      an       <= w_an;
      evt_tick <= w_evt;
    end
  end

endmodule

// File: tb/tb_countdown_display.sv
// Directed bench for countdown_display with SCAN_DIV = 4.
module tb_countdown_display;

  localparam int SCAN_DIV = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] in_val;
  logic       in_flag;
  logic [6:0] seg;
  logic [3:0] an;
  logic       evt_tick;

  int n_checks = 0;
  int n_fail   = 0;

  countdown_display #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_val   (in_val),
    .in_flag  (in_flag),
    .seg      (seg),
    .an       (an),
    .evt_tick (evt_tick)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Hold reset for two cycles, release on a falling edge.
  task automatic do_reset();
    @(negedge clk);
    rst     = 1'b1;
    in_flag = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Wait (bounded) for digit idx to be lit and return its segment pattern.
  task automatic capture_digit(input int idx, output logic [6:0] s, output bit found);
    logic [3:0] exp_an;
    exp_an = ~(4'b0001 << idx);
    found  = 1'b0;
    s      = 7'h00;
    for (int i = 0; i < 24 && !found; i++) begin
      @(negedge clk);
      if (an === exp_an) begin
        found = 1'b1;
        s     = seg;
      end
    end
  endtask

  task automatic test_reset();
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    rst     = 1'b1;
    in_val  = 4'd10;
    in_flag = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (seg !== 7'h7F) begin n_fail++; $display("FAIL reset_seg: got %h want 7f", seg); end
    n_checks++;
    if (an !== 4'hF) begin n_fail++; $display("FAIL reset_an: got %b want 1111", an); end
    n_checks++;
    if (evt_tick !== 1'b0) begin n_fail++; $display("FAIL reset_evt_tick: got %b want 0", evt_tick); end
    rst = 1'b0;
    // One full frame: 4 cycles per digit, starting at the first edge.
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      exp_an = ~(4'b0001 << (c / 4));
      case (c / 4)
        1:       exp_seg = 7'h79;
        default: exp_seg = 7'h40;
      endcase
      n_checks++;
      if (an !== exp_an) begin n_fail++; $display("FAIL scan_an[%0d]: got %b want %b", c, an, exp_an); end
      n_checks++;
      if (seg !== exp_seg) begin n_fail++; $display("FAIL scan_seg[%0d]: got %h want %h", c, seg, exp_seg); end
    end
  endtask

  task automatic test_value_digits();
    logic [6:0] s;
    bit found;
    in_val = 4'd7;
    repeat (4) @(negedge clk);
    capture_digit(1, s, found);
    n_checks++;
    if (!found || s !== 7'h7F) begin n_fail++; $display("FAIL val7_tens_blank: got %h found %0d want 7f", s, found); end
    capture_digit(0, s, found);
    n_checks++;
    if (!found || s !== 7'h78) begin n_fail++; $display("FAIL val7_ones: got %h found %0d want 78", s, found); end
    in_val = 4'd15;
    repeat (4) @(negedge clk);
    capture_digit(1, s, found);
    n_checks++;
    if (!found || s !== 7'h79) begin n_fail++; $display("FAIL val15_tens: got %h found %0d want 79", s, found); end
    capture_digit(0, s, found);
    n_checks++;
    if (!found || s !== 7'h12) begin n_fail++; $display("FAIL val15_ones: got %h found %0d want 12", s, found); end
    in_val = 4'd10;
  endtask

  task automatic test_events();
    logic [6:0] s;
    bit found;
    for (int t = 0; t < 12; t++) begin
      @(negedge clk);
      in_flag = ~in_flag;
      @(negedge clk);
      n_checks++;
      if (evt_tick !== 1'b0) begin n_fail++; $display("FAIL evt_early[%0d]: got %b want 0", t, evt_tick); end
      @(negedge clk);
      n_checks++;
      if (evt_tick !== 1'b1) begin n_fail++; $display("FAIL evt_pulse[%0d]: got %b want 1", t, evt_tick); end
      @(negedge clk);
      n_checks++;
      if (evt_tick !== 1'b0) begin n_fail++; $display("FAIL evt_single[%0d]: got %b want 0", t, evt_tick); end
      repeat (2) @(negedge clk);
    end
    capture_digit(3, s, found);
    n_checks++;
    if (!found || s !== 7'h79) begin n_fail++; $display("FAIL evt12_tens: got %h found %0d want 79", s, found); end
    capture_digit(2, s, found);
    n_checks++;
    if (!found || s !== 7'h24) begin n_fail++; $display("FAIL evt12_ones: got %h found %0d want 24", s, found); end
  endtask

  task automatic test_wrap();
    logic [6:0] s;
    bit found;
    do_reset();
    for (int t = 0; t < 101; t++) begin
      @(negedge clk);
      in_flag = ~in_flag;
      @(negedge clk);
    end
    in_flag = 1'b1;
    repeat (4) @(negedge clk);
    capture_digit(3, s, found);
    n_checks++;
    if (!found || s !== 7'h40) begin n_fail++; $display("FAIL wrap_tens: got %h found %0d want 40", s, found); end
    capture_digit(2, s, found);
    n_checks++;
    if (!found || s !== 7'h79) begin n_fail++; $display("FAIL wrap_ones: got %h found %0d want 79", s, found); end
  endtask

  task automatic test_back_to_back();
    logic [6:0]  s;
    bit          found;
    logic [11:0] mask;
    int          cnt;
    do_reset();
    mask = 12'h000;
    cnt  = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (evt_tick === 1'b1) begin
        cnt++;
        mask[i] = 1'b1;
      end
      if (i < 6) in_flag = ~in_flag;
    end
    n_checks++;
    if (cnt != 6) begin n_fail++; $display("FAIL b2b_count: got %0d want 6", cnt); end
    n_checks++;
    if (mask !== 12'b0000_1111_1100) begin n_fail++; $display("FAIL b2b_timing: got %b want 000011111100", mask); end
    capture_digit(2, s, found);
    n_checks++;
    if (!found || s !== 7'h02) begin n_fail++; $display("FAIL b2b_ones: got %h found %0d want 02", s, found); end
    capture_digit(3, s, found);
    n_checks++;
    if (!found || s !== 7'h40) begin n_fail++; $display("FAIL b2b_tens: got %h found %0d want 40", s, found); end
  endtask

  task automatic test_async_reset();
    logic [6:0] s;
    bit found;
    do_reset();
    for (int t = 0; t < 37; t++) begin
      @(negedge clk);
      in_flag = ~in_flag;
      @(negedge clk);
    end
    repeat (4) @(negedge clk);
    capture_digit(3, s, found);
    n_checks++;
    if (!found || s !== 7'h30) begin n_fail++; $display("FAIL cnt37_tens: got %h found %0d want 30", s, found); end
    capture_digit(2, s, found);
    n_checks++;
    if (!found || s !== 7'h78) begin n_fail++; $display("FAIL cnt37_ones: got %h found %0d want 78", s, found); end
    // Assert reset between clock edges, mid-frame.
    capture_digit(1, s, found);
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (seg !== 7'h7F) begin n_fail++; $display("FAIL async_seg: got %h want 7f", seg); end
    n_checks++;
    if (an !== 4'hF) begin n_fail++; $display("FAIL async_an: got %b want 1111", an); end
    in_flag = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (an !== 4'b1110) begin n_fail++; $display("FAIL restart_an: got %b want 1110", an); end
    n_checks++;
    if (seg !== 7'h40) begin n_fail++; $display("FAIL restart_seg: got %h want 40", seg); end
    capture_digit(2, s, found);
    n_checks++;
    if (!found || s !== 7'h40) begin n_fail++; $display("FAIL cleared_ones: got %h found %0d want 40", s, found); end
    capture_digit(3, s, found);
    n_checks++;
    if (!found || s !== 7'h40) begin n_fail++; $display("FAIL cleared_tens: got %h found %0d want 40", s, found); end
  endtask

  initial begin
    rst     = 1'b1;
    in_val  = 4'd10;
    in_flag = 1'b0;
    test_reset();
    test_value_digits();
    test_events();
    test_wrap();
    test_back_to_back();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/countdown_display.md
# countdown_display

Downstream display stage for the 10-to-1 down-counter.
- Consumes the counter's 4-bit count value and its toggling divide flag.
- Renders both on a 4-digit, common-anode, time-multiplexed seven-segment display:
  - digits 1:0 show the live count (1..10);
  - digits 3:2 show a decimal count of flag toggles (00..99).
- Sits between the counter and the board's segment/anode pins, in the same clock domain as the counter.

## Interface
- SCAN_DIV, default 50000: clock cycles each digit stays lit; legal range 2..2^20.
- clk  in  1  system clock; same clock as the upstream counter.
- rst  in  1  asynchronous, active-high reset.
- in_val  in  4  count value from upstream; nominally 1..10, all 16 codes accepted.
- in_flag  in  1  divide flag from upstream; every edge counts as one event.
- seg  out  7  segment drive {g,f,e,d,c,b,a}, active-low.
- an  out  4  digit enables, active-low, one-hot-cold; an[0] is the rightmost digit.
- evt_tick  out  1  one-cycle pulse per detected in_flag edge.

## Operation
- Input stage: val_r and flag_r register in_val and in_flag every cycle. flag_d registers flag_r.
- Edge detect:
  - evt = flag_r XOR flag_d.
  - evt_tick is the registered form of evt.
- Event counter: two BCD digits, evt_tens:evt_ones.
  - On evt, ones increments.
  - When ones is 9, ones goes to 0 and tens increments.
  - 99 wraps to 00.
- Value conversion, combinational from val_r:
  - 0..9: tens = BLANK, ones = val_r.
  - 10..15: tens = 1, ones = val_r − 10.
- Digit map (scan index → digit code):
  - 0 → val ones.
  - 1 → val tens; BLANK gives leading-zero suppression.
  - 2 → evt_ones.
  - 3 → evt_tens. Never blanked, so "00" is shown.
- Scan divider:
  - div_cnt counts 0..SCAN_DIV−1.
  - At terminal count, div_cnt goes to 0 and scan index advances 0→1→2→3→0.
- Output stage:
  - seg and an are registered every cycle from the current scan index and the decoded digit code.
  - an = ~(4'b0001 << idx).
  - BLANK code (4'hF) drives seg = 7'h7F. Codes 0..9 drive the standard patterns.
- Reset values (asynchronous, all registers):
  - seg = 7'h7F, an = 4'hF, evt_tick = 0.
  - val_r = 0, flag_r = 0, flag_d = 0.
  - Event counter = 00, idx = 0, div_cnt = 0.
- Boundary rules:
  - If in_flag is 1 when reset releases, exactly one event is counted. Upstream holds in_flag at 0 through reset, so this does not occur in-system.
  - in_flag toggling on consecutive cycles counts every edge; no debounce.
  - in_val changes mid-scan update the next registered seg value. No frame latching.
  - Reset asserted mid-scan blanks the display immediately and clears the event count.

## Timing
- Event latency:
  - in_flag changes before clk edge k, so flag_r updates at edge k.
  - evt is high during cycle k..k+1.
  - Counter and evt_tick update at edge k+1.
- Display latency: seg/an reflect any internal change 1 cycle later.
- Digit period: each digit is lit for exactly SCAN_DIV cycles. Full frame = 4×SCAN_DIV cycles.
- First output after reset release:
  - At edge 1, an = 4'b1110.
  - seg shows val ones of reset val_r (0 → 7'h40).
- An index change and its new segment pattern appear on the same edge; no ghosting cycle.

## Structure
- Package seg7_pkg holds:
  - the segment pattern constants for 0..9;
  - SEG_BLANK = 7'h7F;
  - BLANK_CODE = 4'hF;
  - the 2-bit digit-index type.
- Sub-module seg7_decode: combinational 4-bit code to 7-bit active-low pattern.
  - Instantiated once, after the digit mux.
  - Reusable by other display labs.
- Top holds:
  - the input registers;
  - the edge detector;
  - the BCD event counter;
  - the scan divider/index;
  - the output registers.

## Test plan (SCAN_DIV = 4)
- Reset release, in_val = 10, in_flag = 0:
  - → an cycles 1110, 1101, 1011, 0111, 4 cycles each.
  - → seg sequence 7'h40 ("0"), 7'h79 ("1"), 7'h40, 7'h40.
- in_val = 7 steady:
  - → digit 1 blank (seg = 7'h7F while an = 1101).
  - → digit 0 shows 7'h78.
- Toggle in_flag 12 times, spaced 5 cycles apart:
  - → 12 single-cycle evt_tick pulses, each 2 cycles after its in_flag edge.
  - → digits 3:2 show "1","2".
- Toggle in_flag 101 times → event counter wraps; digits show "01".
- Toggle in_flag every cycle for 6 cycles → 6 evt_tick pulses, counter = 06.
- Assert rst mid-frame with count 37:
  - → seg = 7'h7F and an = 4'hF immediately, without waiting for a clock.
  - → after release, count = 00 and scanning restarts at digit 0.
